skinny_sbox_layer_seq: RTL and testbench
========================================

SKINNY_SBOX_LAYER_SEQ -- requirements
Module: skinny_sbox_layer_seq

Interface
REQ-001 SHALL have parameter LAT, default 4: pipeline latency in cycles of the external 3-share masked S-box, legal range 1..8.
REQ-002 SHALL have parameter NIB, default 16: nibbles per 64-bit state, fixed at 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to process one S-box layer.
REQ-006 SHALL have ports st1_in, st2_in, st3_in, input, 64 bits each: the three Boolean shares of the cipher state.
REQ-007 SHALL have ports sb_in1, sb_in2, sb_in3, output, 4 bits each: the nibble shares driven to the external masked S-box.
REQ-008 SHALL have ports sb_out1, sb_out2, sb_out3, input, 4 bits each: the nibble shares returned by the external masked S-box.
REQ-009 SHALL have ports st1_out, st2_out, st3_out, output, 64 bits each: the internal share registers.
REQ-010 SHALL have port busy, output, 1 bit: high while a layer is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking layer completion.

Function
REQ-012 SHALL keep three 64-bit share registers; share k SHALL only ever be combined with share k, with no cross-share logic anywhere.
REQ-013 SHALL use no fresh randomness.
REQ-014 SHALL implement FSM states IDLE -> FEED -> DRAIN -> DONE -> IDLE.
REQ-015 In IDLE or DONE, start=1 SHALL capture st1_in..st3_in, reset the feed counter to 0 and enter FEED.
REQ-016 start SHALL be ignored in FEED and DRAIN.
REQ-017 FEED SHALL last exactly 16 cycles; in feed cycle k (0..15), sb_inX SHALL equal share-X bits [4k+3:4k], driven combinationally from the share register and feed counter.
REQ-018 Outside FEED, sb_in1..3 SHALL be driven 4'h0.
REQ-019 A LAT-deep valid shift register SHALL track issued nibbles, and a separate 4-bit write counter SHALL track write-back position.
REQ-020 When the delayed valid is high, sb_outX SHALL be written into nibble [write counter] of share register X, and the write counter SHALL then increment.
REQ-021 Write-back of nibble k SHALL occur exactly LAT cycles after nibble k was fed.
REQ-022 Feed and write-back of different nibbles SHALL overlap, and must not disturb one another.
REQ-023 After the 16th feed, the FSM SHALL enter DRAIN and stay there until the 16th write-back, then enter DONE.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0; in all other states done SHALL be 0.
REQ-025 busy SHALL be 1 in FEED and DRAIN and 0 otherwise.
REQ-026 Timing: with start sampled at edge 0, busy SHALL be high in cycles 1..LAT+16 and done SHALL be high in cycle LAT+17.
REQ-027 A start arriving in the DONE cycle SHALL be accepted, giving back-to-back layers with no idle gap.
REQ-028 Both counters SHALL wrap 15 -> 0 without affecting state.
REQ-029 st1_out..st3_out SHALL continuously reflect the share registers; they are valid for consumption when done=1.

Reset
REQ-030 rst=1 SHALL, at the next edge, force IDLE, clear all share registers, both counters and the valid pipeline, and drive busy=0, done=0, sb_in1..3=0 and st*_out=0.
REQ-031 rst SHALL take priority over start.
REQ-032 rst asserted mid-FEED or mid-DRAIN SHALL abort the layer with no done pulse; results still in flight SHALL be discarded.

Verification
REQ-033 Bench SHALL pair the block with a LAT-cycle 3-share SKINNY-64 S-box model; S table: 0..f -> c,6,9,0,1,a,2,b,3,8,5,d,4,e,7,f.
REQ-034 Scenario, all-zero input: shares 0,0,0 with start -> recombined XOR of outputs = 64'hCCCCCCCCCCCCCCCC, done high in cycle LAT+17.
REQ-035 Scenario, known value: random shares recombining to 64'h0123456789ABCDEF -> recombined output 64'hC6901A2B385D4E7F, and each output share differs from its input share.
REQ-036 Scenario, start during busy: start pulsed at cycle 5 -> ignored, output unchanged, exactly one done pulse.
REQ-037 Scenario, reset mid-layer: rst at feed cycle 8 -> next cycle busy=0, st*_out=0, no done pulse; a following start completes correctly.
REQ-038 Scenario, back-to-back: start held high through the DONE cycle -> second done exactly LAT+17 cycles after the first; recombined result = S applied twice nibble-wise (0 -> 4).
REQ-039 Scenario, LAT=1 build: all of the above pass with done in cycle 18.

Source files
------------

// File: rtl/skinny_sbox_layer_seq.sv
// Sequencer for one SKINNY-64 S-box layer: feeds the 16 nibbles of three Boolean shares
// through an external LAT-cycle masked S-box and writes each result back in place.
module skinny_sbox_layer_seq #(
  parameter int LAT = 4,
  parameter int NIB = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] st1_in,
  input  logic [63:0] st2_in,
  input  logic [63:0] st3_in,
  output logic [3:0]  sb_in1,
  output logic [3:0]  sb_in2,
  output logic [3:0]  sb_in3,
  input  logic [3:0]  sb_out1,
  input  logic [3:0]  sb_out2,
  input  logic [3:0]  sb_out3,
  output logic [63:0] st1_out,
  output logic [63:0] st2_out,
  output logic [63:0] st3_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_NIB = 4'(NIB - 1);

  state_t         state_r, state_nxt_s;
  logic [63:0]    sh1_r, sh2_r, sh3_r;
  logic [3:0]     feed_cnt_r, wr_cnt_r;
  logic [LAT-1:0] vld_r, vld_nxt_s;
  logic           busy_r, done_r;
  logic           accept_s, feed_s, wb_s;

  function automatic logic [3:0] get_nib(input logic [63:0] v, input logic [3:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] put_nib(input logic [63:0] v, input logic [3:0] idx,
                                          input logic [3:0] n);
    logic [63:0] r;
    r = v;
    r[{idx, 2'b00} +: 4] = n;
    return r;
  endfunction

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign feed_s   = (state_r == FEED);
  assign wb_s     = vld_r[LAT-1];

  // Next-state decode; start is only looked at in IDLE and DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = FEED; else state_nxt_s = IDLE;
      FEED:    if (feed_cnt_r == LAST_NIB) state_nxt_s = DRAIN; else state_nxt_s = FEED;
      DRAIN:   if (wb_s && (wr_cnt_r == LAST_NIB)) state_nxt_s = DONE; else state_nxt_s = DRAIN;
      DONE:    if (start) state_nxt_s = FEED; else state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Issue-valid pipeline, aligned with the external S-box latency
  always_comb begin
    vld_nxt_s    = '0;
    vld_nxt_s[0] = feed_s;
    for (int i = 1; i < LAT; i++) vld_nxt_s[i] = vld_r[i-1];
  end

  // Nibble presented to the masked S-box; each share only sees its own register
  always_comb begin
    if (feed_s) begin
      sb_in1 = get_nib(sh1_r, feed_cnt_r);
      sb_in2 = get_nib(sh2_r, feed_cnt_r);
      sb_in3 = get_nib(sh3_r, feed_cnt_r);
    end else begin
      sb_in1 = 4'h0;
      sb_in2 = 4'h0;
      sb_in3 = 4'h0;
    end
  end

  // State, counters and share registers; feed reads and write-back touch different nibbles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sh1_r      <= 64'h0;
      sh2_r      <= 64'h0;
      sh3_r      <= 64'h0;
      feed_cnt_r <= 4'h0;
      wr_cnt_r   <= 4'h0;
      vld_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      vld_r   <= vld_nxt_s;
      busy_r  <= (state_nxt_s == FEED) || (state_nxt_s == DRAIN);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        sh1_r      <= st1_in;
        sh2_r      <= st2_in;
        sh3_r      <= st3_in;
        feed_cnt_r <= 4'h0;
        wr_cnt_r   <= 4'h0;
      end else begin
        if (feed_s) feed_cnt_r <= feed_cnt_r + 4'h1;
        if (wb_s) begin
          sh1_r    <= put_nib(sh1_r, wr_cnt_r, sb_out1);
          sh2_r    <= put_nib(sh2_r, wr_cnt_r, sb_out2);
          sh3_r    <= put_nib(sh3_r, wr_cnt_r, sb_out3);
          wr_cnt_r <= wr_cnt_r + 4'h1;
        end
      end
    end
  end

  assign st1_out = sh1_r;
  assign st2_out = sh2_r;
  assign st3_out = sh3_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Directed bench: the sequencer paired with a LAT-cycle 3-share SKINNY-64 S-box model.
module tb_skinny_sbox_layer_seq;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, lb;
  logic [63:0] st1_in, st2_in, st3_in, st1_out, st2_out, st3_out;
  logic [63:0] d1, d2, d3;
  logic [3:0]  sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
  logic [3:0]  m1, m2, m3;
  logic [11:0] pipe [LAT];

  int total = 0;
  int bad   = 0;
  int done_cyc[$];
  int busy_first, busy_last;

  always #5 clk = ~clk;

  skinny_sbox_layer_seq #(.LAT(LAT), .NIB(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .st1_in(st1_in), .st2_in(st2_in), .st3_in(st3_in),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
    .st1_out(st1_out), .st2_out(st2_out), .st3_out(st3_out),
    .busy(busy), .done(done)
  );

  // Loopback mode feeds the previous layer's shares straight back in
  assign st1_in = lb ? st1_out : d1;
  assign st2_in = lb ? st2_out : d2;
  assign st3_in = lb ? st3_out : d3;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hc;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
      4'h4: return 4'h1;  4'h5: return 4'ha;  4'h6: return 4'h2;  4'h7: return 4'hb;
      4'h8: return 4'h3;  4'h9: return 4'h8;  4'ha: return 4'h5;  4'hb: return 4'hd;
      4'hc: return 4'h4;  4'hd: return 4'he;  4'he: return 4'h7;  default: return 4'hf;
    endcase
  endfunction

  // Masked S-box model: LAT register stages, then remask shares 2 and 3
  always @(posedge clk) begin
    pipe[0] <= {sb_in1, sb_in2, sb_in3};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign m1 = pipe[LAT-1][11:8];
  assign m2 = pipe[LAT-1][7:4];
  assign m3 = pipe[LAT-1][3:0];
  assign sb_out2 = m2 ^ 4'h5;
  assign sb_out3 = m3 ^ 4'ha;
  assign sb_out1 = sbox(m1 ^ m2 ^ m3) ^ sb_out2 ^ sb_out3;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(negedge clk);
    d1 = a; d2 = b; d3 = c;
    start = 1'b1;
  endtask

  // Observes ncyc cycles after the start edge; optionally pulses start/rst or holds start
  task automatic run(input int ncyc, input int pulse_at, input int rst_at, input bit hold);
    done_cyc.delete();
    busy_first = 0;
    busy_last  = 0;
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (done) done_cyc.push_back(n);
      if (busy) begin
        if (busy_first == 0) busy_first = n;
        busy_last = n;
      end
      if (rst_at != 0 && n == rst_at + 1) begin
        check_eq("rst_busy", {63'h0, busy}, 64'h0);
        check_eq("rst_st", st1_out | st2_out | st3_out, 64'h0);
      end
      start = hold ? (done_cyc.size() < 2) : (n == pulse_at);
      if (n == pulse_at) d1 = ~d1;
      rst = (n == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  function automatic int first_done();
    return (done_cyc.size() > 0) ? done_cyc[0] : -1;
  endfunction

  initial begin
    logic [63:0] k2, k3, k1;
    k2 = 64'h3A5F_9C10_7E2B_D486;
    k3 = 64'hB1C4_0F9E_2657_A83D;
    k1 = 64'h0123_4567_89AB_CDEF ^ k2 ^ k3;
    rst = 1'b1; start = 1'b1; lb = 1'b0;
    d1 = 64'h0; d2 = 64'h0; d3 = 64'h0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", {63'h0, busy}, 64'h0);
    check_eq("reset_done", {63'h0, done}, 64'h0);
    check_eq("reset_st1", st1_out, 64'h0);
    check_eq("reset_st23", st2_out | st3_out, 64'h0);
    check_eq("reset_sbin", {52'h0, sb_in1, sb_in2, sb_in3}, 64'h0);
    rst = 1'b0; start = 1'b0;

    kick(64'h0, 64'h0, 64'h0);
    run(LAT + 25, 0, 0, 1'b0);
    check_eq("zero_ndone", done_cyc.size(), 1);
    check_eq("zero_done_cyc", first_done(), LAT + 17);
    check_eq("zero_busy_first", busy_first, 1);
    check_eq("zero_busy_last", busy_last, LAT + 16);
    check_eq("zero_result", st1_out ^ st2_out ^ st3_out, 64'hCCCC_CCCC_CCCC_CCCC);
    check_eq("idle_sbin", {52'h0, sb_in1, sb_in2, sb_in3}, 64'h0);

    kick(k1, k2, k3);
    run(LAT + 25, 0, 0, 1'b0);
    check_eq("known_result", st1_out ^ st2_out ^ st3_out, 64'hC690_1A2B_385D_4E7F);
    check_eq("known_sh1_diff", {63'h0, st1_out != k1}, 64'h1);
    check_eq("known_sh2_diff", {63'h0, st2_out != k2}, 64'h1);
    check_eq("known_sh3_diff", {63'h0, st3_out != k3}, 64'h1);
    check_eq("known_done_cyc", first_done(), LAT + 17);

    kick(k1, k2, k3);
    run(LAT + 25, 5, 0, 1'b0);
    check_eq("busy_start_result", st1_out ^ st2_out ^ st3_out, 64'hC690_1A2B_385D_4E7F);
    check_eq("busy_start_ndone", done_cyc.size(), 1);

    kick(k1, k2, k3);
    run(LAT + 25, 0, 9, 1'b0);
    check_eq("rst_ndone", done_cyc.size(), 0);
    kick(k1, k2, k3);
    run(LAT + 25, 0, 0, 1'b0);
    check_eq("after_rst_result", st1_out ^ st2_out ^ st3_out, 64'hC690_1A2B_385D_4E7F);
    check_eq("after_rst_done_cyc", first_done(), LAT + 17);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lb  = 1'b1;
    kick(64'h0, 64'h0, 64'h0);
    run(2 * LAT + 45, 0, 0, 1'b1);
    lb = 1'b0;
    check_eq("b2b_ndone", done_cyc.size(), 2);
    check_eq("b2b_first", first_done(), LAT + 17);
    check_eq("b2b_gap", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, LAT + 17);
    check_eq("b2b_result", st1_out ^ st2_out ^ st3_out, 64'h4444_4444_4444_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
